// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared definitions for the system-control register block.
//   - IOC addresses of the register map
//   - default identity constants and soft-reset key
//   - soft-reset generator state type
package sys_ctrl_pkg;

    localparam logic [7:0] IOC_MODULE_VER = 8'h00;
    localparam logic [7:0] IOC_SYSTEM_VER = 8'h01;
    localparam logic [7:0] IOC_MANU_ID    = 8'h02;
    localparam logic [7:0] IOC_LIVE_ERR   = 8'h03;
    localparam logic [7:0] IOC_SOFT_RST   = 8'h04;
    localparam logic [7:0] IOC_STICKY_ERR = 8'h05;
    localparam logic [7:0] IOC_IRQ_MASK   = 8'h06;
    localparam logic [7:0] IOC_SCRATCH    = 8'h07;
    localparam logic [7:0] IOC_ERR_CNT    = 8'h08;

    localparam logic [7:0] MODULE_VER_DEF = 8'h02;
    localparam logic [7:0] SYSTEM_VER_DEF = 8'h01;
    localparam logic [7:0] MANU_ID_DEF    = 8'h01;
    localparam logic [7:0] RST_KEY_DEF    = 8'hA5;

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } srst_state_t;

endpackage

// File: rtl/soft_reset_gen.sv
// soft_reset_gen: fixed-length soft-reset pulse generator.
//   i_sys_clk    - system clock
//   i_reset      - synchronous active-high reset; restarts the power-on stretch
//   i_trigger    - one-cycle keyed request; ignored while a pulse is running
//   o_soft_reset - high while in PULSE (RST_LEN cycles per trigger)
// Reset parks the FSM in PULSE with a full count, so the output stays high
// through reset and for RST_LEN cycles after its release.
module soft_reset_gen
    import sys_ctrl_pkg::*;
#(
    parameter int RST_LEN = 16
) (
    input  logic i_sys_clk,
    input  logic i_reset,
    input  logic i_trigger,
    output logic o_soft_reset
);

    localparam int              CNT_W    = $clog2(RST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    srst_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            state <= PULSE;
            cnt   <= CNT_LOAD;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (i_trigger) begin
                    state_nxt = PULSE;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            PULSE: begin
                // Triggers are ignored here: no retrigger, no extension.
                if (cnt == CNT_ONE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign o_soft_reset = (state == PULSE);

endmodule

// File: rtl/sys_ctrl_regs.sv
// sys_ctrl_regs: system-control register block on the IOC bus.
//   i_sys_clk, i_reset          - clock, synchronous active-high reset
//   i_ioc, i_data_in            - register address, write data
//   i_cs, i_fetch_cmd, i_load_cmd - select, read strobe, write strobe
//   o_data_out                  - read data, one cycle after the fetch, held otherwise
//   i_error_list                - live error flags
//   o_soft_reset                - soft-reset pulse (power-on stretch and keyed)
//   o_irq                       - registered OR of sticky & mask
// Optional: define SYS_CTRL_ERR_CNT_EN for the saturating error-event counter
// at IOC 0x08; without it 0x08 reads 0 and no counter exists.
module sys_ctrl_regs
    import sys_ctrl_pkg::*;
#(
    parameter int              IOC_W      = 5,
    parameter int              DATA_W     = 8,
    parameter int              ERR_W      = 8,
    parameter int              RST_LEN    = 16,
    parameter logic [DATA_W-1:0] RST_KEY    = DATA_W'(RST_KEY_DEF),
    parameter logic [DATA_W-1:0] MODULE_VER = DATA_W'(MODULE_VER_DEF),
    parameter logic [DATA_W-1:0] SYSTEM_VER = DATA_W'(SYSTEM_VER_DEF),
    parameter logic [DATA_W-1:0] MANU_ID    = DATA_W'(MANU_ID_DEF)
) (
    input  logic              i_sys_clk,
    input  logic              i_reset,
    input  logic [IOC_W-1:0]  i_ioc,
    input  logic [DATA_W-1:0] i_data_in,
    output logic [DATA_W-1:0] o_data_out,
    input  logic              i_cs,
    input  logic              i_fetch_cmd,
    input  logic              i_load_cmd,
    input  logic [ERR_W-1:0]  i_error_list,
    output logic              o_soft_reset,
    output logic              o_irq
);

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [IOC_W-1:0]  addr;
        logic [DATA_W-1:0] wdata;
    } ioc_req_t;

    ioc_req_t req;

    // Fetch wins over load when both strobes are high.
    always_comb begin
        req.rd    = i_cs & i_fetch_cmd;
        req.wr    = i_cs & i_load_cmd & ~i_fetch_cmd;
        req.addr  = i_ioc;
        req.wdata = i_data_in;
    end

    logic wr_srst, wr_sticky, wr_mask, wr_scratch;
    assign wr_srst    = req.wr && (req.addr == IOC_W'(IOC_SOFT_RST));
    assign wr_sticky  = req.wr && (req.addr == IOC_W'(IOC_STICKY_ERR));
    assign wr_mask    = req.wr && (req.addr == IOC_W'(IOC_IRQ_MASK));
    assign wr_scratch = req.wr && (req.addr == IOC_W'(IOC_SCRATCH));

    logic trigger, pulse_entry;
    assign trigger     = wr_srst && (req.wdata == RST_KEY);
    // The generator only accepts a trigger when idle, i.e. output low.
    assign pulse_entry = trigger && !o_soft_reset;

    soft_reset_gen #(.RST_LEN(RST_LEN)) u_srst (
        .i_sys_clk   (i_sys_clk),
        .i_reset     (i_reset),
        .i_trigger   (trigger),
        .o_soft_reset(o_soft_reset)
    );

    logic [ERR_W-1:0]  err_live, sticky, sticky_nxt, mask, w1c;
    logic [DATA_W-1:0] scratch, rdata;

    // Set beats clear: new error flags are ORed in after the W1C.
    always_comb begin
        w1c        = wr_sticky ? req.wdata[ERR_W-1:0] : '0;
        sticky_nxt = pulse_entry ? '0 : ((sticky & ~w1c) | i_error_list);
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            err_live <= '0;
            sticky   <= '0;
            mask     <= '0;
            scratch  <= '0;
            o_irq    <= 1'b0;
        end else begin
            err_live <= i_error_list;
            sticky   <= sticky_nxt;
            o_irq    <= |(sticky & mask);
            if (pulse_entry) begin
                mask    <= '0;
                scratch <= '0;
            end else begin
                if (wr_mask)    mask    <= req.wdata[ERR_W-1:0];
                if (wr_scratch) scratch <= req.wdata;
            end
        end
    end

`ifdef SYS_CTRL_ERR_CNT_EN
    logic [7:0] err_cnt;
    logic       wr_cnt, err_rise;
    assign wr_cnt   = req.wr && (req.addr == IOC_W'(IOC_ERR_CNT));
    assign err_rise = |(sticky_nxt & ~sticky);

    always_ff @(posedge i_sys_clk) begin
        if (i_reset || pulse_entry) begin
            err_cnt <= '0;
        end else if (wr_cnt) begin
            // A clear coinciding with a new event leaves a count of one.
            err_cnt <= {7'd0, err_rise};
        end else if (err_rise && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (req.addr)
            IOC_W'(IOC_MODULE_VER): rdata = MODULE_VER;
            IOC_W'(IOC_SYSTEM_VER): rdata = SYSTEM_VER;
            IOC_W'(IOC_MANU_ID):    rdata = MANU_ID;
            IOC_W'(IOC_LIVE_ERR):   rdata[ERR_W-1:0] = err_live;
            IOC_W'(IOC_STICKY_ERR): rdata[ERR_W-1:0] = sticky;
            IOC_W'(IOC_IRQ_MASK):   rdata[ERR_W-1:0] = mask;
            IOC_W'(IOC_SCRATCH):    rdata = scratch;
`ifdef SYS_CTRL_ERR_CNT_EN
            IOC_W'(IOC_ERR_CNT):    rdata = DATA_W'(err_cnt);
`endif
            default:                rdata = '0;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset)     o_data_out <= '0;
        else if (req.rd) o_data_out <= rdata;
    end

endmodule

// File: tb/tb_sys_ctrl_regs.sv
// tb_sys_ctrl_regs: directed and random stimulus for sys_ctrl_regs, checked
// against a register-level behavioural model of the block.
module tb_sys_ctrl_regs;

    localparam int RST_LEN = 16;
    localparam int KEY     = 'hA5;

    logic       clk = 1'b0;
    logic       rst, cs, fe, ld;
    logic [4:0] ioc;
    logic [7:0] din, err;
    logic [7:0] dout;
    logic       srst, irq;

    always #5 clk = ~clk;

    sys_ctrl_regs dut (
        .i_sys_clk   (clk),
        .i_reset     (rst),
        .i_ioc       (ioc),
        .i_data_in   (din),
        .o_data_out  (dout),
        .i_cs        (cs),
        .i_fetch_cmd (fe),
        .i_load_cmd  (ld),
        .i_error_list(err),
        .o_soft_reset(srst),
        .o_irq       (irq)
    );

    int errors = 0;
    int checks = 0;

    // Model state: register contents plus remaining soft-reset cycles.
    int m_sticky, m_mask, m_scratch, m_live, m_irq, m_cnt, m_srst, m_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_read(input int a);
        case (a)
            0: return 2;
            1: return 1;
            2: return 1;
            3: return m_live;
            5: return m_sticky;
            6: return m_mask;
            7: return m_scratch;
`ifdef SYS_CTRL_ERR_CNT_EN
            8: return m_cnt;
`endif
            default: return 0;
        endcase
    endfunction

    // One clock: advance the model from the current inputs, step the DUT,
    // compare all outputs.
    task automatic tick();
        int a, d, e, rd, wr, entry, w1c, s_nxt, rise;
        int n_dout, n_irq, n_mask, n_scr, n_cnt;
        a = int'(ioc); d = int'(din); e = int'(err);
        if (rst) begin
            m_sticky = 0; m_mask = 0; m_scratch = 0; m_live = 0;
            m_irq = 0; m_cnt = 0; m_dout = 0; m_srst = RST_LEN;
        end else begin
            rd     = (cs && fe) ? 1 : 0;
            wr     = (cs && ld && !fe) ? 1 : 0;
            entry  = (m_srst == 0 && wr == 1 && a == 4 && d == KEY) ? 1 : 0;
            w1c    = (wr == 1 && a == 5) ? d : 0;
            s_nxt  = entry ? 0 : (((m_sticky & ~w1c) | e) & 'hFF);
            rise   = ((s_nxt & ~m_sticky) != 0) ? 1 : 0;
            n_dout = rd ? m_read(a) : m_dout;
            n_irq  = ((m_sticky & m_mask) != 0) ? 1 : 0;
            n_mask = entry ? 0 : ((wr == 1 && a == 6) ? d : m_mask);
            n_scr  = entry ? 0 : ((wr == 1 && a == 7) ? d : m_scratch);
            if (entry)                    n_cnt = 0;
            else if (wr == 1 && a == 8)   n_cnt = rise;
            else if (rise && m_cnt < 255) n_cnt = m_cnt + 1;
            else                          n_cnt = m_cnt;
            if (m_srst > 0)  m_srst--;
            else if (entry)  m_srst = RST_LEN;
            m_sticky = s_nxt; m_mask = n_mask; m_scratch = n_scr;
            m_live = e; m_irq = n_irq; m_cnt = n_cnt; m_dout = n_dout;
        end
        @(posedge clk);
        #1;
        chk("dout", 32'(dout), 32'(m_dout));
        chk("irq",  32'(irq),  32'(m_irq));
        chk("srst", 32'(srst), (m_srst > 0) ? 32'd1 : 32'd0);
    endtask

    task automatic idle_bus();
        cs = 1'b0; fe = 1'b0; ld = 1'b0;
    endtask

    task automatic wr_reg(input int a, input int d);
        cs = 1'b1; fe = 1'b0; ld = 1'b1; ioc = 5'(a); din = 8'(d);
        tick();
        idle_bus();
    endtask

    task automatic rd_reg(input string tag, input int a, input int exp);
        cs = 1'b1; fe = 1'b1; ld = 1'b0; ioc = 5'(a);
        tick();
        idle_bus();
        chk(tag, 32'(dout), 32'(exp));
    endtask

    // Counts cycles o_soft_reset stays high; bounded so a stuck pulse fails.
    task automatic count_pulse(input string tag, input int retrig_at);
        int n;
        n = 0;
        while (srst && n < 40) begin
            if (n == retrig_at) wr_reg(4, KEY);
            else                tick();
            n++;
        end
        chk(tag, 32'(n), 32'(RST_LEN));
    endtask

    int exp_cnt;

    initial begin
        rst = 1'b1; idle_bus(); ioc = '0; din = '0; err = '0;
        repeat (3) tick();
        chk("rst_srst", 32'(srst), 32'd1);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_irq",  32'(irq),  32'd0);
        rst = 1'b0;
        count_pulse("poweron_len", -1);

        // Identity and reset contents.
        rd_reg("rd_modver", 0, 'h02);
        tick();
        chk("dout_hold", 32'(dout), 32'h02);
        rd_reg("rd_sysver", 1, 'h01);
        rd_reg("rd_manu",   2, 'h01);
        rd_reg("rd_undef",  'h1F, 'h00);
        for (int a = 3; a <= 8; a++) rd_reg("rd_reset_val", a, 0);

        // Scratch, and fetch-wins-over-load.
        wr_reg(7, 'h3C);
        rd_reg("rd_scratch", 7, 'h3C);
        cs = 1'b1; fe = 1'b1; ld = 1'b1; ioc = 5'd7; din = 8'hFF;
        tick();
        idle_bus();
        rd_reg("scratch_fetch_wins", 7, 'h3C);
        wr_reg(0, 'h77);
        rd_reg("ro_write_ignored", 0, 'h02);

        // Sticky errors, mask, irq.
        err = 8'h05; tick(); err = 8'h00;
        wr_reg(6, 'h04);
        rd_reg("sticky_05", 5, 'h05);
        chk("irq_set", 32'(irq), 32'd1);
        wr_reg(5, 'h04);
        tick();
        chk("irq_clr", 32'(irq), 32'd0);
        rd_reg("sticky_01", 5, 'h01);
        wr_reg(5, 'h01);
        rd_reg("sticky_00", 5, 'h00);
        cs = 1'b1; ld = 1'b1; fe = 1'b0; ioc = 5'd5; din = 8'h01; err = 8'h01;
        tick();
        idle_bus(); err = 8'h00;
        rd_reg("set_beats_clr", 5, 'h01);
        rd_reg("rd_live", 3, 'h00);

        // Soft reset: wrong key, keyed pulse with retrigger at cycle 5.
        wr_reg(4, 'h5A);
        tick(); tick();
        chk("badkey_nopulse", 32'(srst), 32'd0);
        wr_reg(4, KEY);
        chk("key_pulse_start", 32'(srst), 32'd1);
        count_pulse("key_pulse_len", 4);
        rd_reg("clr_scratch", 7, 0);
        rd_reg("clr_mask",    6, 0);
        rd_reg("clr_sticky",  5, 0);
        rd_reg("rd_srst_wo",  4, 0);

        // i_reset in the middle of a pulse restarts the full stretch.
        wr_reg(4, KEY);
        repeat (7) tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("mid_rst_high", 32'(srst), 32'd1);
        rst = 1'b0;
        count_pulse("mid_rst_len", -1);

        // Error-event counter: 300 separate 0->1 transitions of bit 0.
        for (int i = 0; i < 300; i++) begin
            err = 8'h01; tick(); err = 8'h00;
            wr_reg(5, 'h01);
            if (i == 9) begin
`ifdef SYS_CTRL_ERR_CNT_EN
                exp_cnt = 10;
`else
                exp_cnt = 0;
`endif
                rd_reg("cnt_10", 8, exp_cnt);
            end
        end
`ifdef SYS_CTRL_ERR_CNT_EN
        exp_cnt = 'hFF;
`else
        exp_cnt = 0;
`endif
        rd_reg("cnt_sat", 8, exp_cnt);
        wr_reg(8, 0);
        rd_reg("cnt_clr", 8, 0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            cs  = ($urandom_range(0, 3) != 0);
            fe  = 1'($urandom);
            ld  = 1'($urandom);
            ioc = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
            din = ($urandom_range(0, 5) == 0) ? 8'(KEY) : 8'($urandom);
            err = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            tick();
        end
        rst = 1'b0; idle_bus(); err = 8'h00;
        for (int a = 0; a <= 8; a++) rd_reg("final_rd", a, m_read(a));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
